// File: rtl/share_access_sched.sv
// Serialising scheduler for the shared column bank group. It accepts one batch of
// request flags and addresses, then grants each flagged requestor in turn, lowest index first.
module share_access_sched #(
    parameter int SHARED_BANK_NUM    = 5,
    parameter int RQST_ADDR_BITWIDTH = 2,
    parameter int IDX_W              = $clog2(SHARED_BANK_NUM),
    parameter int CNT_W              = $clog2(SHARED_BANK_NUM + 1)
) (
    input  logic                                         sys_clk,
    input  logic                                         rst,
    input  logic                                         rqst_valid_i,
    input  logic [SHARED_BANK_NUM-1:0]                   share_rqstFlag_i,
    input  logic [RQST_ADDR_BITWIDTH*SHARED_BANK_NUM-1:0] rqst_addr_i,
    output logic                                         rqst_ready_o,
    output logic                                         grant_valid_o,
    input  logic                                         grant_ready_i,
    output logic [SHARED_BANK_NUM-1:0]                   grant_o,
    output logic [IDX_W-1:0]                             grant_idx_o,
    output logic [RQST_ADDR_BITWIDTH-1:0]                grant_addr_o,
    output logic [CNT_W-1:0]                             pending_cnt_o,
    output logic                                         batch_done_o
);

    localparam int ADDR_W = RQST_ADDR_BITWIDTH * SHARED_BANK_NUM;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                    state, state_n;
    logic [SHARED_BANK_NUM-1:0] pending, pending_n;
    logic [ADDR_W-1:0]          addr_lat, addr_n;

    logic [SHARED_BANK_NUM-1:0]    sel_vec;
    logic [IDX_W-1:0]              sel_idx;
    logic [RQST_ADDR_BITWIDTH-1:0] sel_addr;
    logic [CNT_W-1:0]              pend_cnt;

    // NOTE: every signal gets a default before the loop so no path leaves one unassigned (no latch).
    always_comb begin
        sel_vec  = '0;
        sel_idx  = '0;
        sel_addr = '0;
        for (int i = SHARED_BANK_NUM - 1; i >= 0; i--) begin
            if (pending[i]) begin
                sel_vec  = '0;
                sel_vec[i] = 1'b1;
                sel_idx  = IDX_W'(i);
                sel_addr = addr_lat[i*RQST_ADDR_BITWIDTH +: RQST_ADDR_BITWIDTH];
            end
        end
    end

    always_comb begin
        pend_cnt = '0;
        for (int i = 0; i < SHARED_BANK_NUM; i++) begin
            pend_cnt = pend_cnt + CNT_W'(pending[i]);
        end
    end

    always_comb begin
        state_n   = state;
        pending_n = pending;
        addr_n    = addr_lat;
        unique case (state)
            IDLE: begin
                if (rqst_valid_i) begin
                    pending_n = share_rqstFlag_i;
                    addr_n    = rqst_addr_i;
                    state_n   = (|share_rqstFlag_i) ? SERVE : DONE;
                end
            end
            SERVE: begin
                if (grant_ready_i) begin
                    pending_n = pending & ~sel_vec;
                    if (pending_n == '0) begin
                        state_n = DONE;
                    end
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all of them update together on the edge.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            pending  <= '0;
            addr_lat <= '0;
        end else begin
            state    <= state_n;
            pending  <= pending_n;
            addr_lat <= addr_n;
        end
    end

    // Every output is decoded from registered state; grant_ready_i only steers the next state.
    always_comb begin
        rqst_ready_o  = (state == IDLE);
        grant_valid_o = (state == SERVE);
        batch_done_o  = (state == DONE);
        grant_o       = (state == SERVE) ? sel_vec  : '0;
        grant_idx_o   = (state == SERVE) ? sel_idx  : '0;
        grant_addr_o  = (state == SERVE) ? sel_addr : '0;
        pending_cnt_o = pend_cnt;
    end

endmodule

// File: tb/tb_share_access_sched.sv
// Directed bench for share_access_sched. Each scenario checks the whole packed
// output vector cycle by cycle against hand-derived expected values.
module tb_share_access_sched;

    logic       sys_clk;
    logic       rst;
    logic       rqst_valid_i;
    logic [4:0] share_rqstFlag_i;
    logic [9:0] rqst_addr_i;
    logic       rqst_ready_o;
    logic       grant_valid_o;
    logic       grant_ready_i;
    logic [4:0] grant_o;
    logic [2:0] grant_idx_o;
    logic [1:0] grant_addr_o;
    logic [2:0] pending_cnt_o;
    logic       batch_done_o;

    int checks;
    int failures;

    share_access_sched dut (
        .sys_clk         (sys_clk),
        .rst             (rst),
        .rqst_valid_i    (rqst_valid_i),
        .share_rqstFlag_i(share_rqstFlag_i),
        .rqst_addr_i     (rqst_addr_i),
        .rqst_ready_o    (rqst_ready_o),
        .grant_valid_o   (grant_valid_o),
        .grant_ready_i   (grant_ready_i),
        .grant_o         (grant_o),
        .grant_idx_o     (grant_idx_o),
        .grant_addr_o    (grant_addr_o),
        .pending_cnt_o   (pending_cnt_o),
        .batch_done_o    (batch_done_o)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    // Packed order: ready, gvalid, grant[4:0], idx[2:0], addr[1:0], cnt[2:0], done
    function automatic logic [15:0] outs();
        return {rqst_ready_o, grant_valid_o, grant_o, grant_idx_o, grant_addr_o,
                pending_cnt_o, batch_done_o};
    endfunction

    function automatic logic [15:0] ev(input logic r, input logic gv, input logic [4:0] g,
                                       input logic [2:0] idx, input logic [1:0] a,
                                       input logic [2:0] cnt, input logic d);
        return {r, gv, g, idx, a, cnt, d};
    endfunction

    localparam logic [15:0] IDLE_V = 16'b1_0_00000_000_00_000_0;
    localparam logic [15:0] DONE_V = 16'b0_0_00000_000_00_000_1;

    task automatic next_cycle();
        @(posedge sys_clk);
        @(negedge sys_clk);
    endtask

    // Call at a negedge: presents a batch accepted at the following rising edge (edge k).
    task automatic offer(input logic [4:0] flags, input logic [9:0] addr);
        rqst_valid_i     = 1'b1;
        share_rqstFlag_i = flags;
        rqst_addr_i      = addr;
    endtask

    task automatic test_reset();
        logic [15:0] obs;
        #3;
        obs = outs();
        checks++;
        if (obs !== IDLE_V) begin
            failures++;
            $display("FAIL reset_initial got=%b exp=%b", obs, IDLE_V);
        end
        @(negedge sys_clk);
        rst = 1'b0;
        next_cycle();
        obs = outs();
        checks++;
        if (obs !== IDLE_V) begin
            failures++;
            $display("FAIL reset_released got=%b exp=%b", obs, IDLE_V);
        end
        offer(5'b00001, 10'b00_00_00_00_11);
        next_cycle();
        rqst_valid_i = 1'b0;
        obs = outs();
        checks++;
        if (obs !== ev(0, 1, 5'b00001, 3'd0, 2'b11, 3'd1, 0)) begin
            failures++;
            $display("FAIL reset_pre_grant got=%b exp=%b", obs, ev(0, 1, 5'b00001, 3'd0, 2'b11, 3'd1, 0));
        end
        // Assert reset between edges; outputs must clear without waiting for a clock.
        #2 rst = 1'b1;
        #1 obs = outs();
        checks++;
        if (obs !== IDLE_V) begin
            failures++;
            $display("FAIL reset_async got=%b exp=%b", obs, IDLE_V);
        end
        @(negedge sys_clk);
        rst = 1'b0;
        next_cycle();
        obs = outs();
        checks++;
        if (obs !== IDLE_V) begin
            failures++;
            $display("FAIL reset_no_done got=%b exp=%b", obs, IDLE_V);
        end
    endtask

    task automatic test_basic();
        logic [15:0] exp_v [4];
        exp_v = '{ev(0, 1, 5'b00100, 3'd2, 2'b10, 3'd2, 0),
                  ev(0, 1, 5'b10000, 3'd4, 2'b11, 3'd1, 0),
                  DONE_V,
                  IDLE_V};
        grant_ready_i = 1'b1;
        offer(5'b10100, 10'b11_01_10_00_01);
        for (int c = 0; c < 4; c++) begin
            next_cycle();
            rqst_valid_i = 1'b0;
            checks++;
            if (outs() !== exp_v[c]) begin
                failures++;
                $display("FAIL basic k+%0d got=%b exp=%b", c + 1, outs(), exp_v[c]);
            end
        end
    endtask

    task automatic test_back_pressure();
        logic [15:0] exp_v [7];
        logic        rdy   [7];
        exp_v = '{ev(0, 1, 5'b00100, 3'd2, 2'b10, 3'd2, 0),
                  ev(0, 1, 5'b00100, 3'd2, 2'b10, 3'd2, 0),
                  ev(0, 1, 5'b00100, 3'd2, 2'b10, 3'd2, 0),
                  ev(0, 1, 5'b00100, 3'd2, 2'b10, 3'd2, 0),
                  ev(0, 1, 5'b10000, 3'd4, 2'b11, 3'd1, 0),
                  DONE_V,
                  IDLE_V};
        rdy = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        offer(5'b10100, 10'b11_01_10_00_01);
        for (int c = 0; c < 7; c++) begin
            next_cycle();
            rqst_valid_i  = 1'b0;
            grant_ready_i = rdy[c];
            checks++;
            if (outs() !== exp_v[c]) begin
                failures++;
                $display("FAIL back_pressure k+%0d got=%b exp=%b", c + 1, outs(), exp_v[c]);
            end
        end
    endtask

    task automatic test_empty();
        logic [15:0] exp_v [2];
        exp_v = '{DONE_V, IDLE_V};
        grant_ready_i = 1'b1;
        offer(5'b00000, 10'b11_11_11_11_11);
        for (int c = 0; c < 2; c++) begin
            next_cycle();
            rqst_valid_i = 1'b0;
            checks++;
            if (outs() !== exp_v[c]) begin
                failures++;
                $display("FAIL empty k+%0d got=%b exp=%b", c + 1, outs(), exp_v[c]);
            end
        end
    endtask

    // A second batch is held on the inputs from k+1; it is only taken once the scheduler is idle (k+7).
    task automatic test_full_ignored();
        logic [15:0] exp_v [10];
        exp_v = '{ev(0, 1, 5'b00001, 3'd0, 2'b11, 3'd5, 0),
                  ev(0, 1, 5'b00010, 3'd1, 2'b00, 3'd4, 0),
                  ev(0, 1, 5'b00100, 3'd2, 2'b01, 3'd3, 0),
                  ev(0, 1, 5'b01000, 3'd3, 2'b11, 3'd2, 0),
                  ev(0, 1, 5'b10000, 3'd4, 2'b10, 3'd1, 0),
                  DONE_V,
                  IDLE_V,
                  ev(0, 1, 5'b00001, 3'd0, 2'b01, 3'd1, 0),
                  DONE_V,
                  IDLE_V};
        grant_ready_i = 1'b1;
        offer(5'b11111, 10'b10_11_01_00_11);
        for (int c = 0; c < 10; c++) begin
            next_cycle();
            if (c < 7) offer(5'b00001, 10'b01_01_01_01_01);
            else rqst_valid_i = 1'b0;
            checks++;
            if (outs() !== exp_v[c]) begin
                failures++;
                $display("FAIL full_ignored k+%0d got=%b exp=%b", c + 1, outs(), exp_v[c]);
            end
        end
    endtask

    task automatic test_reset_mid_serve();
        logic [15:0] exp_v [3];
        logic [15:0] obs;
        grant_ready_i = 1'b1;
        offer(5'b10110, 10'b00_01_11_10_00);
        next_cycle();
        rqst_valid_i = 1'b0;
        checks++;
        if (outs() !== ev(0, 1, 5'b00010, 3'd1, 2'b10, 3'd3, 0)) begin
            failures++;
            $display("FAIL mid_first_grant got=%b exp=%b", outs(), ev(0, 1, 5'b00010, 3'd1, 2'b10, 3'd3, 0));
        end
        next_cycle();
        checks++;
        if (outs() !== ev(0, 1, 5'b00100, 3'd2, 2'b11, 3'd2, 0)) begin
            failures++;
            $display("FAIL mid_second_grant got=%b exp=%b", outs(), ev(0, 1, 5'b00100, 3'd2, 2'b11, 3'd2, 0));
        end
        #2 rst = 1'b1;
        #1 obs = outs();
        checks++;
        if (obs !== IDLE_V) begin
            failures++;
            $display("FAIL mid_reset got=%b exp=%b", obs, IDLE_V);
        end
        @(negedge sys_clk);
        rst = 1'b0;
        for (int c = 0; c < 2; c++) begin
            next_cycle();
            checks++;
            if (outs() !== IDLE_V) begin
                failures++;
                $display("FAIL mid_no_done c%0d got=%b exp=%b", c, outs(), IDLE_V);
            end
        end
        exp_v = '{ev(0, 1, 5'b00010, 3'd1, 2'b01, 3'd1, 0), DONE_V, IDLE_V};
        offer(5'b00010, 10'b00_00_00_01_00);
        for (int c = 0; c < 3; c++) begin
            next_cycle();
            rqst_valid_i = 1'b0;
            checks++;
            if (outs() !== exp_v[c]) begin
                failures++;
                $display("FAIL mid_after_reset k+%0d got=%b exp=%b", c + 1, outs(), exp_v[c]);
            end
        end
    endtask

    initial begin
        checks           = 0;
        failures         = 0;
        rst              = 1'b1;
        rqst_valid_i     = 1'b0;
        share_rqstFlag_i = '0;
        rqst_addr_i      = '0;
        grant_ready_i    = 1'b0;
        test_reset();
        test_basic();
        test_back_pressure();
        test_empty();
        test_full_ignored();
        test_reset_mid_serve();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
